// File: rtl/axi_read_responder.sv
// rtl/axi_read_responder.sv - AXI4 read-channel subordinate serving R beats from an internal 64-bit-word memory
module axi_read_responder #(
    parameter int                    ID_WIDTH   = 13,
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    MEM_WORDS  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ID_WIDTH-1:0]          s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic [7:0]                   s_axi_arlen,
    input  logic [2:0]                   s_axi_arsize,
    input  logic [1:0]                   s_axi_arburst,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [ID_WIDTH-1:0]          s_axi_rid,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    input  logic                         init_we,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
    input  logic [DATA_WIDTH-1:0]        init_data
);
    localparam int IW = $clog2(MEM_WORDS);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q, count_q;
    logic [1:0]            burst_q;
    logic                  err_q;

    logic                  ar_hs, r_hs, ar_err, beat_err, in_range;
    logic [ADDR_WIDTH-1:0] incr_addr, wrap_mask, next_addr, beat_addr, off, off_words;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [1:0]            beat_resp;

    assign s_axi_arready = (state_q == IDLE) && !reset;
    assign ar_hs         = s_axi_arvalid && s_axi_arready;
    assign r_hs          = s_axi_rvalid && s_axi_rready;

    assign ar_err = (s_axi_arsize != 3'b011) || (s_axi_arburst == 2'b11) ||
                    ((s_axi_arburst == 2'b10) && !((s_axi_arlen == 8'd1) || (s_axi_arlen == 8'd3) ||
                                                   (s_axi_arlen == 8'd7) || (s_axi_arlen == 8'd15)));

    // Legal WRAP lengths are 2^n-1, so the wrap window mask (W-1) is just {len, 3'b111}.
    assign incr_addr = addr_q + ADDR_WIDTH'(8);
    assign wrap_mask = {{(ADDR_WIDTH-11){1'b0}}, len_q, 3'b111};

    always_comb begin
        next_addr = addr_q;
        case (burst_q)
            2'b01:   next_addr = incr_addr;
            2'b10:   next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = addr_q;
        endcase
    end

    assign beat_addr = ar_hs ? {s_axi_araddr[ADDR_WIDTH-1:3], 3'b000} : next_addr;
    assign beat_err  = ar_hs ? ar_err : err_q;
    assign off       = beat_addr - BASE_ADDR;
    assign off_words = off >> 3;
    assign in_range  = (beat_addr >= BASE_ADDR) && (off_words < ADDR_WIDTH'(MEM_WORDS));
    assign beat_data = (beat_err || !in_range) ? '0 : mem[off_words[IW-1:0]];
    assign beat_resp = (beat_err || !in_range) ? 2'b10 : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ar_hs) state_d = BURST;
            BURST:   if (r_hs && s_axi_rlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rlast  <= 1'b0;
            s_axi_rid    <= '0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= 2'b00;
            addr_q       <= '0;
            len_q        <= '0;
            count_q      <= '0;
            burst_q      <= 2'b00;
            err_q        <= 1'b0;
        end else if (ar_hs) begin
            s_axi_rid    <= s_axi_arid;
            s_axi_rvalid <= 1'b1;
            s_axi_rlast  <= (s_axi_arlen == 8'd0);
            s_axi_rdata  <= beat_data;
            s_axi_rresp  <= beat_resp;
            addr_q       <= beat_addr;
            len_q        <= s_axi_arlen;
            count_q      <= '0;
            burst_q      <= s_axi_arburst;
            err_q        <= ar_err;
        end else if (r_hs) begin
            if (s_axi_rlast) begin
                s_axi_rvalid <= 1'b0;
                s_axi_rlast  <= 1'b0;
            end else begin
                s_axi_rlast  <= ((count_q + 8'd1) == len_q);
                s_axi_rdata  <= beat_data;
                s_axi_rresp  <= beat_resp;
                addr_q       <= beat_addr;
                count_q      <= count_q + 8'd1;
            end
        end
    end

    // Preload port; a beat loaded on the same edge sees the old word.
    always_ff @(posedge clk) begin
        if (init_we) mem[init_addr] <= init_data;
    end
endmodule
